// File: rtl/clock_time_keeper.sv
// Seconds/minutes/hours timekeeper with 1 Hz prescaler, manual setting and
// registered active-low 7-segment outputs for the clock-face renderer.
module clock_time_keeper #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       mode24,
  input  logic       set_en,
  input  logic       inc_hr,
  input  logic       inc_min,
  output logic       sec_tick,
  output logic [6:0] h1,
  output logic [6:0] h2,
  output logic [6:0] m1,
  output logic [6:0] m2,
  output logic [6:0] s1,
  output logic [6:0] s2,
  output logic [6:0] ap
);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PCNT_MAX = PW'(TICK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_P     = 7'b0011000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Tens digit of a 0..59 value by threshold compares (no divider).
  function automatic logic [3:0] tens60(input logic [5:0] v);
    logic [3:0] t;
    if      (v >= 6'd50) t = 4'd5;
    else if (v >= 6'd40) t = 4'd4;
    else if (v >= 6'd30) t = 4'd3;
    else if (v >= 6'd20) t = 4'd2;
    else if (v >= 6'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] units60(input logic [5:0] v, input logic [3:0] t);
    logic [5:0] r;
    case (t)
      4'd1:    r = v - 6'd10;
      4'd2:    r = v - 6'd20;
      4'd3:    r = v - 6'd30;
      4'd4:    r = v - 6'd40;
      4'd5:    r = v - 6'd50;
      default: r = v;
    endcase
    return r[3:0];
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          prev_hr_q, prev_hr_d;
  logic          prev_min_q, prev_min_d;
  logic          sec_tick_q, sec_tick_d;
  logic [6:0]    h1_q, h1_d, h2_q, h2_d, m1_q, m1_d, m2_q, m2_d;
  logic [6:0]    s1_q, s1_d, s2_q, s2_d, ap_q, ap_d;

  logic          tick;
  logic          hr_rise;
  logic          min_rise;

  // Counter next-state: set mode freezes time, run mode ticks with full carry.
  always_comb begin
    tick       = !set_en && (pcnt_q == PCNT_MAX);
    hr_rise    = inc_hr && !prev_hr_q;
    min_rise   = inc_min && !prev_min_q;

    pcnt_d     = pcnt_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    prev_hr_d  = inc_hr;
    prev_min_d = inc_min;
    sec_tick_d = tick;

    if (set_en) begin
      pcnt_d = '0;
      sec_d  = '0;
      if (hr_rise)  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      if (min_rise) min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end else if (tick) begin
      pcnt_d = '0;
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      pcnt_d = pcnt_q + PW'(1);
    end

    if (RST_BTN) begin
      pcnt_d     = '0;
      sec_d      = '0;
      min_d      = '0;
      hour_d     = '0;
      prev_hr_d  = 1'b0;
      prev_min_d = 1'b0;
      sec_tick_d = 1'b0;
    end
  end

  logic [5:0] disp_sec, disp_min, disp_hour, h12;
  logic [3:0] st, mt, ht, h12u;

  // Display encodes the current (registered) counters, one edge behind them;
  // during reset it encodes 00:00:00 so the outputs reset in the current mode.
  always_comb begin
    disp_sec  = RST_BTN ? 6'd0 : sec_q;
    disp_min  = RST_BTN ? 6'd0 : min_q;
    disp_hour = RST_BTN ? 6'd0 : {1'b0, hour_q};

    st   = tens60(disp_sec);
    mt   = tens60(disp_min);
    ht   = tens60(disp_hour);
    s1_d = seg7(st);
    s2_d = seg7(units60(disp_sec, st));
    m1_d = seg7(mt);
    m2_d = seg7(units60(disp_min, mt));

    if (disp_hour == 6'd0)      h12 = 6'd12;
    else if (disp_hour > 6'd12) h12 = disp_hour - 6'd12;
    else                        h12 = disp_hour;
    h12u = (h12 >= 6'd10) ? units60(h12, 4'd1) : h12[3:0];

    if (mode24) begin
      h1_d = seg7(ht);
      h2_d = seg7(units60(disp_hour, ht));
      ap_d = SEG_BLANK;
    end else begin
      h1_d = (h12 >= 6'd10) ? seg7(4'd1) : SEG_BLANK;
      h2_d = seg7(h12u);
      ap_d = (disp_hour < 6'd12) ? SEG_A : SEG_P;
    end
  end

  always_ff @(posedge CLK) begin
    pcnt_q     <= pcnt_d;
    sec_q      <= sec_d;
    min_q      <= min_d;
    hour_q     <= hour_d;
    prev_hr_q  <= prev_hr_d;
    prev_min_q <= prev_min_d;
    sec_tick_q <= sec_tick_d;
    h1_q       <= h1_d;
    h2_q       <= h2_d;
    m1_q       <= m1_d;
    m2_q       <= m2_d;
    s1_q       <= s1_d;
    s2_q       <= s2_d;
    ap_q       <= ap_d;
  end

  assign sec_tick = sec_tick_q;
  assign h1       = h1_q;
  assign h2       = h2_q;
  assign m1       = m1_q;
  assign m2       = m2_q;
  assign s1       = s1_q;
  assign s2       = s2_q;
  assign ap       = ap_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper with TICK_DIV = 4.
module tb_clock_time_keeper;

  localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010,
                         D3 = 7'b0000110, D5 = 7'b0100100, D9 = 7'b0000100;
  localparam logic [6:0] BLK = 7'b1111111, LA = 7'b0001000, LP = 7'b0011000;

  logic clk = 1'b0;
  logic rst_btn = 1'b0, mode24 = 1'b0, set_en = 1'b0, inc_hr = 1'b0, inc_min = 1'b0;
  logic sec_tick;
  logic [6:0] h1, h2, m1, m2, s1, s2, ap;
  logic [48:0] disp, exp_disp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_time_keeper #(.TICK_DIV(4)) dut (
    .CLK(clk), .RST_BTN(rst_btn), .mode24(mode24), .set_en(set_en),
    .inc_hr(inc_hr), .inc_min(inc_min), .sec_tick(sec_tick),
    .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2), .ap(ap)
  );

  assign disp = {h1, h2, m1, m2, s1, s2, ap};

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_btn = 1'b1;
    step(2);
    rst_btn = 1'b0;
  endtask

  task automatic pulse_hr();
    inc_hr = 1'b1; step(1); inc_hr = 1'b0; step(1);
  endtask

  task automatic pulse_min();
    inc_min = 1'b1; step(1); inc_min = 1'b0; step(1);
  endtask

  task automatic test_reset();
    mode24 = 1'b0; set_en = 1'b0;
    rst_btn = 1'b1;
    step(2);
    checks++;
    if (sec_tick !== 1'b0) begin
      failures++; $display("FAIL reset_tick got=%b exp=0", sec_tick);
    end
    exp_disp = {D1, D2, D0, D0, D0, D0, LA};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL reset_12h got=%b exp=%b", disp, exp_disp);
    end
    mode24 = 1'b1;
    step(1);
    exp_disp = {D0, D0, D0, D0, D0, D0, BLK};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL reset_24h got=%b exp=%b", disp, exp_disp);
    end
    rst_btn = 1'b0; mode24 = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_tick_rate();
    int n_ticks = 0;
    int last = 0;
    mode24 = 1'b0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (sec_tick === 1'b1) begin
        n_ticks++;
        checks++;
        if (i - last !== 4) begin
          failures++; $display("FAIL tick_spacing got=%0d exp=4 at_cycle=%0d", i - last, i);
        end
        last = i;
      end
    end
    checks++;
    if (n_ticks !== 10) begin
      failures++; $display("FAIL tick_count got=%0d exp=10", n_ticks);
    end
    step(1);
    checks++;
    if ({s1, s2} !== {D1, D0}) begin
      failures++; $display("FAIL ten_seconds got=%b exp=%b", {s1, s2}, {D1, D0});
    end
    $display("test_tick_rate ticks=%0d", n_ticks);
  endtask

  task automatic test_full_carry();
    mode24 = 1'b0;
    do_reset();
    set_en = 1'b1;
    repeat (23) pulse_hr();
    repeat (59) pulse_min();
    mode24 = 1'b1; set_en = 1'b0;
    step(237);
    exp_disp = {D2, D3, D5, D9, D5, D9, BLK};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL carry_235959 got=%b exp=%b", disp, exp_disp);
    end
    step(4);
    exp_disp = {D0, D0, D0, D0, D0, D0, BLK};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL carry_000000_24h got=%b exp=%b", disp, exp_disp);
    end
    mode24 = 1'b0;
    step(1);
    exp_disp = {D1, D2, D0, D0, D0, D0, LA};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL carry_120000_12h got=%b exp=%b", disp, exp_disp);
    end
    $display("test_full_carry done");
  endtask

  task automatic test_ampm();
    mode24 = 1'b0;
    do_reset();
    set_en = 1'b1;
    repeat (11) pulse_hr();
    repeat (59) pulse_min();
    set_en = 1'b0;
    step(237);
    exp_disp = {D1, D1, D5, D9, D5, D9, LA};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL ampm_115959 got=%b exp=%b", disp, exp_disp);
    end
    step(4);
    exp_disp = {D1, D2, D0, D0, D0, D0, LP};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL ampm_120000 got=%b exp=%b", disp, exp_disp);
    end
    $display("test_ampm done");
  endtask

  task automatic test_set_mode();
    mode24 = 1'b0;
    do_reset();
    set_en = 1'b1;
    repeat (13) pulse_hr();
    exp_disp = {BLK, D1, D0, D0, D0, D0, LP};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL set_hour13 got=%b exp=%b", disp, exp_disp);
    end
    inc_hr = 1'b1; step(10); inc_hr = 1'b0; step(1);
    checks++;
    if ({h1, h2} !== {BLK, D2}) begin
      failures++; $display("FAIL hold_inc_hr got=%b exp=%b", {h1, h2}, {BLK, D2});
    end
    for (int i = 0; i < 60; i++) begin
      pulse_min();
      if (i == 0) begin
        checks++;
        if ({m1, m2} !== {D0, D1}) begin
          failures++; $display("FAIL set_min1 got=%b exp=%b", {m1, m2}, {D0, D1});
        end
      end
      if (i == 58) begin
        checks++;
        if ({m1, m2} !== {D5, D9}) begin
          failures++; $display("FAIL set_min59 got=%b exp=%b", {m1, m2}, {D5, D9});
        end
      end
    end
    checks++;
    if ({h1, h2, m1, m2} !== {BLK, D2, D0, D0}) begin
      failures++; $display("FAIL min_wrap_no_carry got=%b exp=%b", {h1, h2, m1, m2}, {BLK, D2, D0, D0});
    end
    checks++;
    if ({s1, s2, sec_tick} !== {D0, D0, 1'b0}) begin
      failures++; $display("FAIL set_frozen got=%b exp=%b", {s1, s2, sec_tick}, {D0, D0, 1'b0});
    end
    $display("test_set_mode done");
  endtask

  task automatic test_simultaneous();
    mode24 = 1'b1; set_en = 1'b1;
    inc_hr = 1'b1; inc_min = 1'b1; step(1);
    inc_hr = 1'b0; inc_min = 1'b0; step(1);
    checks++;
    if ({h1, h2, m1, m2} !== {D1, D5, D0, D1}) begin
      failures++; $display("FAIL both_inc got=%b exp=%b", {h1, h2, m1, m2}, {D1, D5, D0, D1});
    end
    set_en = 1'b0;
    inc_hr = 1'b1; inc_min = 1'b1; step(1);
    inc_hr = 1'b0; inc_min = 1'b0; step(2);
    checks++;
    if ({h1, h2, m1, m2} !== {D1, D5, D0, D1}) begin
      failures++; $display("FAIL run_edges_ignored got=%b exp=%b", {h1, h2, m1, m2}, {D1, D5, D0, D1});
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_midrun();
    mode24 = 1'b0;
    do_reset();
    step(3);
    rst_btn = 1'b1;
    step(1);
    checks++;
    if (sec_tick !== 1'b0) begin
      failures++; $display("FAIL midrun_no_tick got=%b exp=0", sec_tick);
    end
    rst_btn = 1'b0;
    step(1);
    exp_disp = {D1, D2, D0, D0, D0, D0, LA};
    checks++;
    if (disp !== exp_disp) begin
      failures++; $display("FAIL midrun_outputs got=%b exp=%b", disp, exp_disp);
    end
    step(2);
    checks++;
    if (sec_tick !== 1'b0) begin
      failures++; $display("FAIL midrun_early_tick got=%b exp=0", sec_tick);
    end
    step(1);
    checks++;
    if (sec_tick !== 1'b1) begin
      failures++; $display("FAIL midrun_first_tick got=%b exp=1", sec_tick);
    end
    $display("test_reset_midrun done");
  endtask

  initial begin
    test_reset();
    test_tick_rate();
    test_full_carry();
    test_ampm();
    test_set_mode();
    test_simultaneous();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
